// File: rtl/sdram_sim_pkg.sv
// Shared types and widths for the SDRAM front-end simulation model.
package sdram_sim_pkg;

    localparam int BankW = 2;
    localparam int RowW  = 13;
    localparam int ColW  = 10;
    localparam int AddrW = BankW + RowW + ColW;
    localparam int DataW = 16;

    // Front-end command encoding; the fourth code is reserved and behaves as idle.
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

endpackage

// File: rtl/sdram_burst_sim_model_if.sv
// Command/data bus between a user of the SDRAM controller and the controller itself.
interface sdram_burst_sim_model_if;
    import sdram_sim_pkg::*;

    logic [1:0]       command;
    logic [AddrW-1:0] data_address;
    logic [DataW-1:0] data_write;
    logic [DataW-1:0] data_read;
    logic             data_read_valid;
    logic             data_write_done;

    modport master (
        output command, data_address, data_write,
        input  data_read, data_read_valid, data_write_done
    );

    modport slave (
        input  command, data_address, data_write,
        output data_read, data_read_valid, data_write_done
    );

endinterface

// File: rtl/sdram_sim_mem.sv
// Single-port word RAM with registered read; stands in for the SDRAM array.
module sdram_sim_mem
    import sdram_sim_pkg::*;
#(
    parameter int AddrWidth = 25
) (
    input  logic                 clk_i,
    input  logic                 we,
    input  logic [AddrWidth-1:0] addr,
    input  logic [DataW-1:0]     wdata,
    output logic [DataW-1:0]     rdata
);

    logic [DataW-1:0] mem_q [0:(1 << AddrWidth) - 1];

    // Write on enable; the read port always returns the addressed word one cycle later.
    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata <= mem_q[addr];
    end

endmodule

// File: rtl/sdram_burst_sim_model.sv
// Behavioural drop-in for the 16-bit SDRAM controller front end: fixed-length
// bursts against an internal RAM, CAS-delayed read data, physical pins tied off.
module sdram_burst_sim_model
    import sdram_sim_pkg::*;
#(
    parameter int SdramClkRate         = 143_000_000,
    parameter int SdramReadBurstLength = 1,
    parameter int SdramWriteBurst      = 0,
    parameter int CasLatency           = 3,
    parameter int MemAddrWidth         = 25
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    sdram_burst_sim_model_if.slave bus,
    output logic                sdram_clk_en_o,
    output logic [BankW-1:0]    sdram_bank_activate_o,
    output logic [RowW-1:0]     sdram_address_o,
    output logic                sdram_cs_o,
    output logic                sdram_row_addr_strobe_o,
    output logic                sdram_column_addr_strobe_o,
    output logic                sdram_we_o,
    output logic [1:0]          sdram_dqm_o,
    inout  wire  [DataW-1:0]    sdram_dq_io
);

    localparam int ReadLen  = SdramReadBurstLength;
    localparam int WriteLen = (SdramWriteBurst != 0) ? ReadLen : 1;

    if (!(ReadLen == 1 || ReadLen == 2 || ReadLen == 4 || ReadLen == 8)) begin : g_bad_bl
        $error("SdramReadBurstLength must be 1, 2, 4 or 8");
    end
    if (!(CasLatency == 2 || CasLatency == 3)) begin : g_bad_cl
        $error("CasLatency must be 2 or 3");
    end
    if (MemAddrWidth < 1 || MemAddrWidth > AddrW) begin : g_bad_maw
        $error("MemAddrWidth must be in 1..25");
    end
    if (SdramClkRate <= 0) begin : g_bad_clk
        $error("SdramClkRate must be positive");
    end

    cmd_e             cmd;
    state_e           state_q, state_d;
    logic [AddrW-1:0] base_q, base_d;
    logic [2:0]       beat_q, beat_d;
    logic [AddrW-1:0] acc_addr;
    logic             mem_we;
    logic             rd_en;
    logic             done_d, done_q;
    logic [DataW-1:0] mem_rdata;
    logic             vld_p0;
    logic             vld_p1;
    logic [DataW-1:0] dat_p1;
    logic             rd_vld_q;
    logic [DataW-1:0] rd_data_q;

    assign cmd      = cmd_e'(bus.command);
    // Burst addresses wrap modulo 2^25 by truncation to the address width.
    assign acc_addr = base_q + AddrW'(beat_q);

    if (MemAddrWidth < AddrW) begin : g_hi_bits
        logic unused_hi;
        assign unused_hi = ^acc_addr[AddrW-1:MemAddrWidth];
    end

    // Next-state logic: commands accepted only in IDLE, one memory access per burst beat.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        beat_d  = beat_q;
        mem_we  = 1'b0;
        rd_en   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd == CMD_WRITE) begin
                    state_d = ST_WRITE;
                    base_d  = bus.data_address;
                    beat_d  = '0;
                    done_d  = 1'b1;
                end else if (cmd == CMD_READ) begin
                    state_d = ST_READ;
                    base_d  = bus.data_address;
                    beat_d  = '0;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (beat_q == 3'(WriteLen - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            ST_READ: begin
                rd_en = 1'b1;
                if (beat_q == 3'(ReadLen - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst base address is pure data and needs no reset.
    always_ff @(posedge clk_i) begin
        base_q <= base_d;
    end

    sdram_sim_mem #(
        .AddrWidth(MemAddrWidth)
    ) u_mem (
        .clk_i (clk_i),
        .we    (mem_we),
        .addr  (acc_addr[MemAddrWidth-1:0]),
        .wdata (bus.data_write),
        .rdata (mem_rdata)
    );

    // Stage p0 -> p1: extra delay slot only for CAS latency 3.
    if (CasLatency == 3) begin : g_cl3
        // Valid bit of the extra CAS stage; cleared by reset so a burst aborts cleanly.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= vld_p0;
            end
        end
        // Data of the extra CAS stage.
        always_ff @(posedge clk_i) begin
            dat_p1 <= mem_rdata;
        end
    end else begin : g_cl2
        assign vld_p1 = vld_p0;
        assign dat_p1 = mem_rdata;
    end

    // Control state, done pulse and the read-valid pipeline; output data is zero when not valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            done_q    <= 1'b0;
            vld_p0    <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
            vld_p0    <= rd_en;
            rd_vld_q  <= vld_p1;
            rd_data_q <= vld_p1 ? dat_p1 : '0;
        end
    end

    assign bus.data_read       = rd_data_q;
    assign bus.data_read_valid = rd_vld_q;
    assign bus.data_write_done = done_q;

    // Physical pins exist only so the model fits the real controller's slot.
    assign sdram_clk_en_o             = 1'b1;
    assign sdram_bank_activate_o      = '0;
    assign sdram_address_o            = '0;
    assign sdram_cs_o                 = 1'b0;
    assign sdram_row_addr_strobe_o    = 1'b0;
    assign sdram_column_addr_strobe_o = 1'b0;
    assign sdram_we_o                 = 1'b0;
    assign sdram_dqm_o                = '0;
    assign sdram_dq_io                = 'z;

endmodule

// File: tb/tb_sdram_burst_sim_model.sv
// Scoreboard bench: three model instances (BL8/WL8/CL3, BL1/WL1/CL2, BL4/WL4/CL2).
module tb_sdram_burst_sim_model;
    import sdram_sim_pkg::*;

    logic clk    = 1'b0;
    logic rst_ni = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } beat_t;

    beat_t       q8[$], q1[$], q4[$];
    logic [15:0] m8[int], m1[int], m4[int];
    logic [15:0] wbuf[8];

    sdram_burst_sim_model_if if8();
    sdram_burst_sim_model_if if1();
    sdram_burst_sim_model_if if4();

    logic        cke8, cs8, ras8, cas8, we8;
    logic [1:0]  ba8, dqm8;
    logic [12:0] a8;
    wire  [15:0] dq8;
    logic        cke1, cs1, ras1, cas1, we1;
    logic [1:0]  ba1, dqm1;
    logic [12:0] a1;
    wire  [15:0] dq1;
    logic        cke4, cs4, ras4, cas4, we4;
    logic [1:0]  ba4, dqm4;
    logic [12:0] a4;
    wire  [15:0] dq4;

    sdram_burst_sim_model #(.SdramReadBurstLength(8), .SdramWriteBurst(1), .CasLatency(3), .MemAddrWidth(10)) u8 (
        .clk_i(clk), .rst_ni(rst_ni), .bus(if8),
        .sdram_clk_en_o(cke8), .sdram_bank_activate_o(ba8), .sdram_address_o(a8),
        .sdram_cs_o(cs8), .sdram_row_addr_strobe_o(ras8), .sdram_column_addr_strobe_o(cas8),
        .sdram_we_o(we8), .sdram_dqm_o(dqm8), .sdram_dq_io(dq8));

    sdram_burst_sim_model #(.SdramReadBurstLength(1), .SdramWriteBurst(0), .CasLatency(2), .MemAddrWidth(6)) u1 (
        .clk_i(clk), .rst_ni(rst_ni), .bus(if1),
        .sdram_clk_en_o(cke1), .sdram_bank_activate_o(ba1), .sdram_address_o(a1),
        .sdram_cs_o(cs1), .sdram_row_addr_strobe_o(ras1), .sdram_column_addr_strobe_o(cas1),
        .sdram_we_o(we1), .sdram_dqm_o(dqm1), .sdram_dq_io(dq1));

    sdram_burst_sim_model #(.SdramReadBurstLength(4), .SdramWriteBurst(1), .CasLatency(2), .MemAddrWidth(6)) u4 (
        .clk_i(clk), .rst_ni(rst_ni), .bus(if4),
        .sdram_clk_en_o(cke4), .sdram_bank_activate_o(ba4), .sdram_address_o(a4),
        .sdram_cs_o(cs4), .sdram_row_addr_strobe_o(ras4), .sdram_column_addr_strobe_o(cas4),
        .sdram_we_o(we4), .sdram_dqm_o(dqm4), .sdram_dq_io(dq4));

    function automatic int bl_of(int sel);
        case (sel) 0: return 8; 1: return 1; default: return 4; endcase
    endfunction
    function automatic int wl_of(int sel);
        case (sel) 0: return 8; 1: return 1; default: return 4; endcase
    endfunction
    function automatic int cl_of(int sel);
        case (sel) 0: return 3; default: return 2; endcase
    endfunction
    function automatic int maw_of(int sel);
        case (sel) 0: return 10; default: return 6; endcase
    endfunction
    function automatic string nm(int sel);
        case (sel) 0: return "u8"; 1: return "u1"; default: return "u4"; endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_bus(input int sel, input logic [1:0] c, input logic [24:0] a);
        case (sel)
            0: begin if8.command = c; if8.data_address = a; end
            1: begin if1.command = c; if1.data_address = a; end
            default: begin if4.command = c; if4.data_address = a; end
        endcase
    endtask

    task automatic set_wdata(input int sel, input logic [15:0] d);
        case (sel)
            0: if8.data_write = d;
            1: if1.data_write = d;
            default: if4.data_write = d;
        endcase
    endtask

    function automatic logic get_done(int sel);
        case (sel) 0: return if8.data_write_done; 1: return if1.data_write_done; default: return if4.data_write_done; endcase
    endfunction
    function automatic logic get_vld(int sel);
        case (sel) 0: return if8.data_read_valid; 1: return if1.data_read_valid; default: return if4.data_read_valid; endcase
    endfunction
    function automatic logic [15:0] get_rdata(int sel);
        case (sel) 0: return if8.data_read; 1: return if1.data_read; default: return if4.data_read; endcase
    endfunction

    function automatic int idx_of(int sel, logic [24:0] a);
        return int'(a) & ((1 << maw_of(sel)) - 1);
    endfunction

    task automatic model_wr(input int sel, input logic [24:0] a, input logic [15:0] d);
        int i = idx_of(sel, a);
        case (sel) 0: m8[i] = d; 1: m1[i] = d; default: m4[i] = d; endcase
    endtask

    function automatic logic [15:0] model_rd(int sel, logic [24:0] a);
        int i = idx_of(sel, a);
        case (sel)
            0: return m8.exists(i) ? m8[i] : 16'h0;
            1: return m1.exists(i) ? m1[i] : 16'h0;
            default: return m4.exists(i) ? m4[i] : 16'h0;
        endcase
    endfunction

    task automatic push(input int sel, input beat_t b);
        case (sel) 0: q8.push_back(b); 1: q1.push_back(b); default: q4.push_back(b); endcase
    endtask

    // Write burst from wbuf; optionally drives READ during the data beats (must be ignored).
    task automatic write_burst(input int sel, input logic [24:0] base, input bit intrude);
        int wl = wl_of(sel);
        set_bus(sel, 2'd1, base);
        @(negedge clk);
        check({nm(sel), "_done_hi"}, 32'(get_done(sel)), 32'd1);
        set_bus(sel, intrude ? 2'd2 : 2'd0, base);
        for (int k = 0; k < wl; k++) begin
            set_wdata(sel, wbuf[k]);
            model_wr(sel, base + 25'(k), wbuf[k]);
            @(negedge clk);
            if (k == 0) check({nm(sel), "_done_lo"}, 32'(get_done(sel)), 32'd0);
        end
        set_bus(sel, 2'd0, base);
    endtask

    task automatic read_issue(input int sel, input logic [24:0] base);
        int c0 = cyc + 1;
        for (int k = 0; k < bl_of(sel); k++) begin
            beat_t b;
            b.data = model_rd(sel, base + 25'(k));
            b.cyc  = c0 + cl_of(sel) + k;
            push(sel, b);
        end
        set_bus(sel, 2'd2, base);
        @(negedge clk);
        set_bus(sel, 2'd0, base);
    endtask

    task automatic read_burst(input int sel, input logic [24:0] base);
        read_issue(sel, base);
        repeat (bl_of(sel)) @(negedge clk);
    endtask

    task automatic mon(input int sel, input logic v, input logic [15:0] d);
        beat_t b;
        bit    have = 1'b0;
        if (v) begin
            case (sel)
                0: if (q8.size() > 0) begin b = q8.pop_front(); have = 1'b1; end
                1: if (q1.size() > 0) begin b = q1.pop_front(); have = 1'b1; end
                default: if (q4.size() > 0) begin b = q4.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                check({nm(sel), "_unexpected_valid"}, 32'(v), 32'd0);
            end else begin
                check({nm(sel), "_beat_data"}, 32'(d), 32'(b.data));
                check({nm(sel), "_beat_cycle"}, 32'(cyc), 32'(b.cyc));
            end
        end else begin
            check({nm(sel), "_idle_data"}, 32'(d), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            mon(0, if8.data_read_valid, if8.data_read);
            mon(1, if1.data_read_valid, if1.data_read);
            mon(2, if4.data_read_valid, if4.data_read);
        end
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            set_bus(s, 2'd0, 25'd0);
            set_wdata(s, 16'd0);
        end
        #2 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check({nm(s), "_rst_valid"}, 32'(get_vld(s)), 32'd0);
            check({nm(s), "_rst_data"}, 32'(get_rdata(s)), 32'd0);
            check({nm(s), "_rst_done"}, 32'(get_done(s)), 32'd0);
        end
        check("u8_pin_tieoff", 32'({cke8, ba8, a8, cs8, ras8, cas8, we8, dqm8}), 32'h0020_0000);
        rst_ni = 1'b1;
        @(negedge clk);

        // Full-length burst write and read-back.
        for (int k = 0; k < 8; k++) wbuf[k] = 16'($urandom);
        write_burst(0, 25'h0123456, 1'b0);
        read_burst(0, 25'h0123456);

        // Single-word write/read.
        wbuf[0] = 16'hBEEF;
        write_burst(1, 25'h0000001, 1'b0);
        read_burst(1, 25'h0000001);

        // Burst wrapping across the top of the address space.
        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333; wbuf[3] = 16'h4444;
        write_burst(2, 25'h0000000, 1'b0);
        wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB; wbuf[2] = 16'hCCCC; wbuf[3] = 16'hDDDD;
        write_burst(2, 25'h1FFFFFE, 1'b0);
        read_burst(2, 25'h1FFFFFE);
        read_burst(2, 25'h0000000);

        // Read command during a write burst is dropped.
        repeat (12) @(negedge clk);
        for (int k = 0; k < 8; k++) wbuf[k] = 16'($urandom);
        write_burst(0, 25'h0000200, 1'b1);
        repeat (12) @(negedge clk);
        read_burst(0, 25'h0000200);

        // Asynchronous reset in the middle of a read burst.
        repeat (12) @(negedge clk);
        for (int k = 0; k < 8; k++) wbuf[k] = 16'($urandom);
        write_burst(0, 25'h0000300, 1'b0);
        read_issue(0, 25'h0000300);
        repeat (5) @(negedge clk);
        #1 rst_ni = 1'b0;
        q8.delete();
        #1;
        check("u8_midrst_valid", 32'(get_vld(0)), 32'd0);
        check("u8_midrst_data", 32'(get_rdata(0)), 32'd0);
        check("u8_midrst_done", 32'(get_done(0)), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        read_burst(0, 25'h0000300);

        // Random write-then-read traffic.
        for (int it = 0; it < 1000; it++) begin
            logic [24:0] base;
            base = 25'($urandom);
            for (int k = 0; k < 8; k++) wbuf[k] = 16'($urandom);
            write_burst(0, base, 1'b0);
            read_burst(0, base);
        end

        repeat (12) @(negedge clk);
        check("u8_beats_missing", 32'(q8.size()), 32'd0);
        check("u1_beats_missing", 32'(q1.size()), 32'd0);
        check("u4_beats_missing", 32'(q4.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
